// File: rtl/rf_wb_if.sv
// Writeback, reservation and hazard-check signals between the pipeline and the
// register-file write-port arbiter.
interface rf_wb_if #(
    parameter int ANCHO = 32,
    parameter int N     = 5
);
    logic             alu_valid;
    logic [N-1:0]     alu_rd;
    logic [ANCHO-1:0] alu_data;
    logic             alu_ready;
    logic             mem_valid;
    logic [N-1:0]     mem_rd;
    logic [ANCHO-1:0] mem_data;
    logic             mem_ready;
    logic             iss_valid;
    logic [N-1:0]     iss_rd;
    logic             iss_ready;
    logic [N-1:0]     chk_rs1;
    logic [N-1:0]     chk_rs2;
    logic             busy1;
    logic             busy2;
    logic             rf_we;
    logic [N-1:0]     rf_addr_rd;
    logic [ANCHO-1:0] rf_data_in;

    modport master (
        output alu_valid, alu_rd, alu_data, input alu_ready,
        output mem_valid, mem_rd, mem_data, input mem_ready,
        output iss_valid, iss_rd, input iss_ready,
        output chk_rs1, chk_rs2, input busy1, busy2,
        input rf_we, rf_addr_rd, rf_data_in
    );

    modport slave (
        input alu_valid, alu_rd, alu_data, output alu_ready,
        input mem_valid, mem_rd, mem_data, output mem_ready,
        input iss_valid, iss_rd, output iss_ready,
        input chk_rs1, chk_rs2, output busy1, busy2,
        output rf_we, rf_addr_rd, rf_data_in
    );
endinterface

// File: rtl/rf_wb_arbiter.sv
// Round-robin arbiter for the single register-file write port (ALU vs MEM) with a
// busy scoreboard of reserved destination registers for RAW/WAW stalls.
module rf_wb_arbiter #(
    parameter int ANCHO = 32,
    parameter int N     = 5
) (
    input  logic     clk,
    input  logic     rst,
    rf_wb_if.slave   bus
);
    localparam int NREG = 2 ** N;

    typedef enum logic {
        GRANT_ALU = 1'b0,
        GRANT_MEM = 1'b1
    } grant_t;

    grant_t           last_grant_r;
    logic [NREG-1:0]  busy_r;
    logic [NREG-1:0]  busy_next_s;
    logic             rf_we_r;
    logic [N-1:0]     rf_addr_rd_r;
    logic [ANCHO-1:0] rf_data_in_r;

    logic             alu_grant_s;
    logic             mem_grant_s;
    logic             iss_ready_s;
    logic             iss_take_s;
    logic             wr_take_s;
    logic [N-1:0]     wr_rd_s;
    logic [ANCHO-1:0] wr_data_s;

    // Grant selection: a lone requester wins, a tie goes to whoever was not served last.
    always_comb begin
        alu_grant_s = 1'b0;
        mem_grant_s = 1'b0;
        if (rst) begin
            alu_grant_s = 1'b0;
            mem_grant_s = 1'b0;
        end else if (bus.alu_valid && bus.mem_valid) begin
            alu_grant_s = (last_grant_r == GRANT_MEM);
            mem_grant_s = (last_grant_r == GRANT_ALU);
        end else begin
            alu_grant_s = bus.alu_valid;
            mem_grant_s = bus.mem_valid;
        end
    end

    // Payload of the granted requester; a transfer to r0 is accepted but never written.
    always_comb begin
        wr_rd_s   = '0;
        wr_data_s = '0;
        if (alu_grant_s) begin
            wr_rd_s   = bus.alu_rd;
            wr_data_s = bus.alu_data;
        end else if (mem_grant_s) begin
            wr_rd_s   = bus.mem_rd;
            wr_data_s = bus.mem_data;
        end else begin
            wr_rd_s   = '0;
            wr_data_s = '0;
        end
    end

    assign wr_take_s   = (alu_grant_s || mem_grant_s) && (wr_rd_s != '0);
    assign iss_ready_s = !rst && !busy_r[bus.iss_rd];
    assign iss_take_s  = bus.iss_valid && iss_ready_s && (bus.iss_rd != '0);

    // Scoreboard update: clear follows the RF write, set follows an accepted reservation.
    always_comb begin
        busy_next_s = busy_r;
        if (rf_we_r) begin
            busy_next_s[rf_addr_rd_r] = 1'b0;
        end else begin
            busy_next_s = busy_r;
        end
        if (iss_take_s) begin
            busy_next_s[bus.iss_rd] = 1'b1;
        end else begin
            busy_next_s[0] = 1'b0;
        end
        busy_next_s[0] = 1'b0;
    end

    // Registered write port, round-robin pointer and scoreboard state.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_r       <= '0;
            rf_we_r      <= 1'b0;
            rf_addr_rd_r <= '0;
            rf_data_in_r <= '0;
            last_grant_r <= GRANT_MEM;
        end else begin
            busy_r  <= busy_next_s;
            rf_we_r <= wr_take_s;
            if (wr_take_s) begin
                rf_addr_rd_r <= wr_rd_s;
                rf_data_in_r <= wr_data_s;
            end
            if (alu_grant_s) begin
                last_grant_r <= GRANT_ALU;
            end else if (mem_grant_s) begin
                last_grant_r <= GRANT_MEM;
            end
        end
    end

    assign bus.alu_ready  = alu_grant_s;
    assign bus.mem_ready  = mem_grant_s;
    assign bus.iss_ready  = iss_ready_s;
    assign bus.busy1      = busy_r[bus.chk_rs1];
    assign bus.busy2      = busy_r[bus.chk_rs2];
    assign bus.rf_we      = rf_we_r;
    assign bus.rf_addr_rd = rf_addr_rd_r;
    assign bus.rf_data_in = rf_data_in_r;
endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed and randomized checks of rf_wb_arbiter against a cycle-level reference
// model of the writeback arbitration and busy scoreboard.
module tb_rf_wb_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;

    rf_wb_if #(.ANCHO(32), .N(5)) bus ();

    rf_wb_arbiter #(.ANCHO(32), .N(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // reference model state (post-reset values)
    bit          m_busy [32];
    bit          m_we        = 1'b0;
    logic [4:0]  m_addr      = 5'd0;
    logic [31:0] m_data      = 32'd0;
    bit          m_last_alu  = 1'b0;
    bit          e_alu, e_mem, e_iss;
    logic        o_alu, o_mem, o_iss, o_we, o_b1, o_b2;
    logic [4:0]  o_addr;
    logic [31:0] o_data;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: compare at the falling edge, advance the model at the rising edge.
    task automatic cyc();
        bit         n_we;
        logic [4:0] n_rd;
        logic [31:0] n_dat;
        @(negedge clk);
        e_alu = !rst && bus.alu_valid && (!bus.mem_valid || !m_last_alu);
        e_mem = !rst && bus.mem_valid && (!bus.alu_valid || m_last_alu);
        e_iss = !rst && !m_busy[bus.iss_rd];
        o_alu = bus.alu_ready;  o_mem = bus.mem_ready;  o_iss = bus.iss_ready;
        o_we = bus.rf_we;  o_addr = bus.rf_addr_rd;  o_data = bus.rf_data_in;
        o_b1 = bus.busy1;  o_b2 = bus.busy2;
        chk("alu_ready", o_alu, e_alu);
        chk("mem_ready", o_mem, e_mem);
        chk("iss_ready", o_iss, e_iss);
        chk("busy1", o_b1, m_busy[bus.chk_rs1]);
        chk("busy2", o_b2, m_busy[bus.chk_rs2]);
        chk("rf_we", o_we, m_we);
        if (m_we) begin
            chk("rf_addr_rd", o_addr, m_addr);
            chk("rf_data_in", o_data, m_data);
        end
        @(posedge clk);
        if (rst) begin
            foreach (m_busy[k]) m_busy[k] = 1'b0;
            m_we = 1'b0;  m_addr = 5'd0;  m_data = 32'd0;  m_last_alu = 1'b0;
        end else begin
            if (m_we) m_busy[m_addr] = 1'b0;
            if (bus.iss_valid && e_iss && bus.iss_rd != 5'd0) m_busy[bus.iss_rd] = 1'b1;
            n_we = 1'b0;  n_rd = 5'd0;  n_dat = 32'd0;
            if (e_alu) begin
                m_last_alu = 1'b1;  n_rd = bus.alu_rd;  n_dat = bus.alu_data;
            end else if (e_mem) begin
                m_last_alu = 1'b0;  n_rd = bus.mem_rd;  n_dat = bus.mem_data;
            end
            n_we = (e_alu || e_mem) && (n_rd != 5'd0);
            m_we = n_we;
            if (n_we) begin
                m_addr = n_rd;  m_data = n_dat;
            end
        end
        #1;
        if (e_alu) bus.alu_valid = 1'b0;
        if (e_mem) bus.mem_valid = 1'b0;
    endtask

    initial begin
        foreach (m_busy[k]) m_busy[k] = 1'b0;
        bus.alu_valid = 1'b1;  bus.alu_rd = 5'd1;  bus.alu_data = 32'h0000_0A01;
        bus.mem_valid = 1'b1;  bus.mem_rd = 5'd2;  bus.mem_data = 32'h0000_0B02;
        bus.iss_valid = 1'b0;  bus.iss_rd = 5'd0;
        bus.chk_rs1 = 5'd1;  bus.chk_rs2 = 5'd2;

        // 1: reset with both requesters pending, then ALU wins the first tie
        rst = 1'b1;
        cyc();
        cyc();
        chk("t1_rst_alu_ready", o_alu, 1'b0);
        chk("t1_rst_mem_ready", o_mem, 1'b0);
        chk("t1_rst_we", o_we, 1'b0);
        rst = 1'b0;
        cyc();
        chk("t1_first_tie_alu", o_alu, 1'b1);
        chk("t1_first_tie_mem", o_mem, 1'b0);
        cyc();
        chk("t1_then_mem", o_mem, 1'b1);
        cyc();

        // 2: single ALU writeback
        bus.alu_valid = 1'b1;  bus.alu_rd = 5'd5;  bus.alu_data = 32'hDEAD_BEEF;
        cyc();
        chk("t2_alu_ready", o_alu, 1'b1);
        cyc();
        chk("t2_we", o_we, 1'b1);
        chk("t2_addr", o_addr, 5'd5);
        chk("t2_data", o_data, 32'hDEAD_BEEF);

        // 3: MEM served alone, then a tie goes ALU then MEM
        bus.mem_valid = 1'b1;  bus.mem_rd = 5'd6;  bus.mem_data = 32'h0000_0066;
        cyc();
        cyc();
        bus.alu_valid = 1'b1;  bus.alu_rd = 5'd3;  bus.alu_data = 32'h0000_0011;
        bus.mem_valid = 1'b1;  bus.mem_rd = 5'd4;  bus.mem_data = 32'h0000_0022;
        cyc();
        chk("t3_grant_alu", o_alu, 1'b1);
        chk("t3_hold_mem", o_mem, 1'b0);
        cyc();
        chk("t3_grant_mem", o_mem, 1'b1);
        chk("t3_we_rd3", o_addr, 5'd3);
        cyc();
        chk("t3_we2", o_we, 1'b1);
        chk("t3_we_rd4", o_addr, 5'd4);
        cyc();
        chk("t3_we_drop", o_we, 1'b0);

        // 4: reserve r7, WAW stall, clear after MEM writeback
        bus.iss_valid = 1'b1;  bus.iss_rd = 5'd7;  bus.chk_rs1 = 5'd7;
        cyc();
        bus.iss_valid = 1'b0;
        cyc();
        chk("t4_busy_set", o_b1, 1'b1);
        bus.iss_valid = 1'b1;
        cyc();
        chk("t4_waw_stall", o_iss, 1'b0);
        bus.iss_valid = 1'b0;
        bus.mem_valid = 1'b1;  bus.mem_rd = 5'd7;  bus.mem_data = 32'h7777_0007;
        cyc();
        cyc();
        chk("t4_still_busy", o_b1, 1'b1);
        cyc();
        chk("t4_busy_clear", o_b1, 1'b0);

        // 5: register 0 writes and reservations are accepted but inert
        bus.alu_valid = 1'b1;  bus.alu_rd = 5'd0;  bus.alu_data = 32'h0000_FFFF;
        bus.iss_valid = 1'b1;  bus.iss_rd = 5'd0;  bus.chk_rs1 = 5'd0;
        cyc();
        chk("t5_r0_accept", o_alu, 1'b1);
        chk("t5_r0_iss", o_iss, 1'b1);
        bus.iss_valid = 1'b0;
        cyc();
        chk("t5_r0_no_we", o_we, 1'b0);
        chk("t5_r0_not_busy", o_b1, 1'b0);

        // 6: simultaneous set of r9 and clear of r10, then reset drops a pending write
        bus.iss_valid = 1'b1;  bus.iss_rd = 5'd10;
        cyc();
        bus.iss_valid = 1'b0;
        bus.alu_valid = 1'b1;  bus.alu_rd = 5'd10;  bus.alu_data = 32'h0000_1010;
        cyc();
        bus.iss_valid = 1'b1;  bus.iss_rd = 5'd9;
        cyc();
        chk("t6_we_r10", o_we, 1'b1);
        bus.iss_valid = 1'b0;  bus.chk_rs1 = 5'd9;  bus.chk_rs2 = 5'd10;
        cyc();
        chk("t6_busy9", o_b1, 1'b1);
        chk("t6_busy10", o_b2, 1'b0);
        bus.alu_valid = 1'b1;  bus.alu_rd = 5'd12;  bus.alu_data = 32'h0000_1212;
        cyc();
        rst = 1'b1;
        cyc();
        chk("t6_pending_we", o_we, 1'b1);
        cyc();
        chk("t6_rst_drop_we", o_we, 1'b0);
        rst = 1'b0;

        // randomized traffic with occasional resets
        for (int i = 0; i < 400; i++) begin
            rst = ($urandom_range(0, 63) == 0);
            if (!bus.alu_valid && $urandom_range(0, 1) == 1) begin
                bus.alu_valid = 1'b1;
                bus.alu_rd    = 5'($urandom_range(0, 11));
                bus.alu_data  = 32'($urandom);
            end
            if (!bus.mem_valid && $urandom_range(0, 1) == 1) begin
                bus.mem_valid = 1'b1;
                bus.mem_rd    = 5'($urandom_range(0, 11));
                bus.mem_data  = 32'($urandom);
            end
            bus.iss_valid = 1'($urandom_range(0, 1));
            bus.iss_rd    = 5'($urandom_range(0, 11));
            bus.chk_rs1   = 5'($urandom_range(0, 11));
            bus.chk_rs2   = 5'($urandom_range(0, 11));
            cyc();
        end
        rst = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
